// File: rtl/mux4_seq_pkg.sv
// Shared types and constants for the HDMUXB4D4 select sequencer.
// Build option: MUX4_SEQ_PARITY_EN adds a trailing parity beat.
package mux4_seq_pkg;

    localparam int NLANES = 4;
    localparam int CNT_W  = 4;

    typedef logic [1:0] lane_t;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETTLE  = 2'd1,
        S_PRESENT = 2'd2,
        S_PARITY  = 2'd3
    } state_t;

    function automatic lane_t step_lane(lane_t l, bit down);
        return down ? l - lane_t'(1) : l + lane_t'(1);
    endfunction

endpackage

// File: rtl/mux4_sel_sequencer_if.sv
// Parallel-in, mux-cell and serial-out signals of the select sequencer.
// slave = sequencer side, master = upstream/cell/sink side.
interface mux4_sel_sequencer_if;

    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic [3:0] mux_a;
    logic [1:0] mux_sl;
    logic       mux_z;
    logic       ser_valid;
    logic       ser_ready;
    logic       ser_data;
    logic       ser_last;

    modport slave (
        input  in_valid, in_data, mux_z, ser_ready,
        output in_ready, mux_a, mux_sl, ser_valid, ser_data, ser_last
    );

    modport master (
        output in_valid, in_data, mux_z, ser_ready,
        input  in_ready, mux_a, mux_sl, ser_valid, ser_data, ser_last
    );

endinterface

// File: rtl/mux4_settle_cnt.sv
// Loadable down-counter timing the per-lane settle window.
module mux4_settle_cnt
    import mux4_seq_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && count != '0) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/mux4_sel_sequencer.sv
// Drives the 4:1 inverting mux cell lane by lane and serialises its output.
// Build option: MUX4_SEQ_PARITY_EN appends an even-parity beat per word.
module mux4_sel_sequencer
    import mux4_seq_pkg::*;
#(
    parameter int HOLD_CYCLES = 1,
    parameter bit MSB_FIRST   = 1'b0
) (
    input logic CK,
    input logic RN,
    mux4_sel_sequencer_if.slave bus
);

    localparam logic [1:0] IDLE    = S_IDLE;
    localparam logic [1:0] SETTLE  = S_SETTLE;
    localparam logic [1:0] PRESENT = S_PRESENT;
`ifdef MUX4_SEQ_PARITY_EN
    localparam logic [1:0] PARITY  = S_PARITY;
`endif

    localparam lane_t FIRST = MSB_FIRST ? lane_t'(NLANES - 1) : lane_t'(0);
    localparam lane_t LAST  = MSB_FIRST ? lane_t'(0) : lane_t'(NLANES - 1);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD_CYCLES - 1);

    logic [1:0] state;
    logic       accept_in;
    logic       beat_acc;
    logic       at_last;
    logic       cnt_load;
    logic       cnt_dec;
    logic       cnt_zero;

    assign bus.in_ready = (state == IDLE);
    assign accept_in    = bus.in_valid & bus.in_ready;
    assign beat_acc     = (state == PRESENT) & bus.ser_ready;
    assign at_last      = (bus.mux_sl == LAST);
    assign cnt_load     = accept_in | (beat_acc & ~at_last);
    assign cnt_dec      = (state == SETTLE) & ~cnt_zero;

    mux4_settle_cnt #(.W(CNT_W)) u_cnt (
        .clk      (CK),
        .rst_n    (RN),
        .load     (cnt_load),
        .load_val (RELOAD),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state         <= IDLE;
            bus.mux_a     <= '0;
            bus.mux_sl    <= '0;
            bus.ser_valid <= 1'b0;
            bus.ser_data  <= 1'b0;
            bus.ser_last  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept_in) begin
                        bus.mux_a  <= bus.in_data;
                        bus.mux_sl <= FIRST;
                        state      <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt_zero) begin
                        // cell output is inverted; undo it here
                        bus.ser_data  <= ~bus.mux_z;
                        bus.ser_valid <= 1'b1;
`ifdef MUX4_SEQ_PARITY_EN
                        bus.ser_last  <= 1'b0;
`else
                        bus.ser_last  <= at_last;
`endif
                        state         <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (bus.ser_ready) begin
                        if (!at_last) begin
                            bus.mux_sl    <= step_lane(bus.mux_sl, MSB_FIRST);
                            bus.ser_valid <= 1'b0;
                            state         <= SETTLE;
                        end else begin
`ifdef MUX4_SEQ_PARITY_EN
                            bus.ser_data  <= ^bus.mux_a;
                            bus.ser_last  <= 1'b1;
                            bus.ser_valid <= 1'b1;
                            state         <= PARITY;
`else
                            bus.ser_valid <= 1'b0;
                            bus.ser_last  <= 1'b0;
                            state         <= IDLE;
`endif
                        end
                    end
                end
`ifdef MUX4_SEQ_PARITY_EN
                PARITY: begin
                    if (bus.ser_ready) begin
                        bus.ser_valid <= 1'b0;
                        bus.ser_last  <= 1'b0;
                        state         <= IDLE;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule
